// File: rtl/cos_pkg.sv
// Shared types and constants for the Q8.8 Taylor-series cosine unit.
// Holds the controller state encoding and the datapath strobe bundle.
package cos_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MULX1,
        S_MULX2,
        S_MULC,
        S_CHECK,
        S_ACC,
        S_DONE
    } cos_state_t;

    localparam logic [15:0] COS_ONE             = 16'h0100;
    localparam int          COS_MAX_TERMS_LIMIT = 8;

    typedef struct packed {
        logic ldx;
        logic ld0cnt;
        logic ld1;
        logic xsel;
        logic rsel;
        logic ldt;
        logic ldr;
        logic en;
        logic addsub;
        logic inccnt;
    } cos_strobe_t;

    // Strobes implied by a state alone; addsub depends on the term parity
    // and is filled in by the controller.
    function automatic cos_strobe_t cos_decode(input cos_state_t s);
        cos_strobe_t w;
        w = '0;
        case (s)
            S_LOAD: begin
                w.ldx    = 1'b1;
                w.ld0cnt = 1'b1;
                w.ld1    = 1'b1;
            end
            S_MULX1, S_MULX2: begin
                w.xsel = 1'b1;
                w.ldt  = 1'b1;
            end
            S_MULC: begin
                w.rsel = 1'b1;
                w.ldt  = 1'b1;
            end
            S_ACC: begin
                w.ldr    = 1'b1;
                w.en     = 1'b1;
                w.inccnt = 1'b1;
            end
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/cos_ctrl.sv
// Moore sequencer for the cosine datapath: multiply x, multiply x, multiply
// coefficient, compare, accumulate, until the term falls below y or the limit.
module cos_ctrl
    import cos_pkg::*;
#(
    parameter int MAX_TERMS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       TLTY,
    input  logic       repcnt0,
    output logic       ldx,
    output logic       ld0cnt,
    output logic       ld1,
    output logic       xsel,
    output logic       rsel,
    output logic       ldt,
    output logic       ldr,
    output logic       en,
    output logic       addsub,
    output logic       inccnt,
    output logic       busy,
    output logic       done,
    output logic [3:0] terms
);

    localparam logic [3:0] MAX_TERMS_W = 4'(MAX_TERMS);

    cos_state_t  state_q, state_d;
    cos_strobe_t strb_q, strb_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  terms_q, terms_d;

    always_comb begin
        state_d = state_q;
        terms_d = terms_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  state_d = S_MULX1;
            S_MULX1: state_d = S_MULX2;
            S_MULX2: state_d = S_MULC;
            S_MULC:  state_d = S_CHECK;
            S_CHECK: state_d = TLTY ? S_ACC : S_DONE;
            S_ACC:   state_d = (terms_q + 4'd1 == MAX_TERMS_W) ? S_DONE : S_MULX1;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && abort)
            state_d = S_IDLE;

        // The ACC strobes fire at this edge even when aborted, so the
        // accumulate did happen and is counted.
        if (state_q == S_IDLE && state_d == S_LOAD)
            terms_d = 4'd0;
        else if (state_q == S_ACC)
            terms_d = terms_q + 4'd1;

        // Outputs are decoded from the next state and registered, so they
        // line up with the state they belong to without an input-to-output path.
        // repcnt0 is stable from CHECK into ACC (it only moves on inccnt).
        strb_d        = cos_decode(state_d);
        strb_d.addsub = (state_d == S_ACC) && repcnt0;
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            strb_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            terms_q <= 4'd0;
        end else begin
            state_q <= state_d;
            strb_q  <= strb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            terms_q <= terms_d;
        end
    end

    assign ldx    = strb_q.ldx;
    assign ld0cnt = strb_q.ld0cnt;
    assign ld1    = strb_q.ld1;
    assign xsel   = strb_q.xsel;
    assign rsel   = strb_q.rsel;
    assign ldt    = strb_q.ldt;
    assign ldr    = strb_q.ldr;
    assign en     = strb_q.en;
    assign addsub = strb_q.addsub;
    assign inccnt = strb_q.inccnt;
    assign busy   = busy_q;
    assign done   = done_q;
    assign terms  = terms_q;

endmodule

// File: tb/tb_cos_ctrl.sv
// Bench for cos_ctrl: directed scenarios plus randomized run lengths checked
// cycle by cycle against an expected strobe trace built from the series rules.
module tb_cos_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       TLTY = 1'b0;
    logic       repcnt0 = 1'b0;
    logic       ldx, ld0cnt, ld1, xsel, rsel, ldt, ldr, en, addsub, inccnt;
    logic       busy, done;
    logic [3:0] terms;

    int checks = 0;
    int errors = 0;

    localparam int MAXT = 8;

    cos_ctrl #(.MAX_TERMS(MAXT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .TLTY(TLTY),
        .repcnt0(repcnt0), .ldx(ldx), .ld0cnt(ld0cnt), .ld1(ld1), .xsel(xsel),
        .rsel(rsel), .ldt(ldt), .ldr(ldr), .en(en), .addsub(addsub),
        .inccnt(inccnt), .busy(busy), .done(done), .terms(terms)
    );

    always #5 clk = ~clk;

    // Stand-in for the datapath term counter LSB.
    always @(posedge clk) begin
        if (!rst || ld0cnt) repcnt0 <= 1'b0;
        else if (inccnt)    repcnt0 <= ~repcnt0;
    end

    wire [9:0]  strb = {ldx, ld0cnt, ld1, xsel, rsel, ldt, ldr, en, addsub, inccnt};
    wire [11:0] obs  = {strb, busy, done};

    // Strobe words: {ldx,ld0cnt,ld1,xsel,rsel,ldt,ldr,en,addsub,inccnt}
    localparam logic [9:0] W_LOAD = 10'b1110000000;
    localparam logic [9:0] W_MX   = 10'b0001010000;
    localparam logic [9:0] W_MC   = 10'b0000110000;
    localparam logic [9:0] W_ACC  = 10'b0000001101;
    localparam logic [9:0] W_NONE = 10'b0000000000;

    logic [11:0] expq[$];

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Expected per-cycle {strobes,busy,done} for a run with n accumulates.
    task automatic build(input int n);
        expq.delete();
        expq.push_back({W_LOAD, 2'b10});
        for (int j = 0; j < n; j++) begin
            expq.push_back({W_MX, 2'b10});
            expq.push_back({W_MX, 2'b10});
            expq.push_back({W_MC, 2'b10});
            expq.push_back({W_NONE, 2'b10});
            expq.push_back({W_ACC | {8'd0, 1'(j % 2), 1'b0}, 2'b10});
        end
        if (n < MAXT) begin
            expq.push_back({W_MX, 2'b10});
            expq.push_back({W_MX, 2'b10});
            expq.push_back({W_MC, 2'b10});
            expq.push_back({W_NONE, 2'b10});
        end
        expq.push_back({W_NONE, 2'b11});
    endtask

    // k = number of CHECKs that see TLTY=1 before the first TLTY=0.
    task automatic run_check(input int k, input string tag);
        int n;
        int done_cyc;
        int ldr_seen;
        n = (k < MAXT) ? k : MAXT;
        done_cyc = 0;
        ldr_seen = 0;
        build(n);
        @(negedge clk);
        start = 1'b1;
        TLTY  = 1'b0;
        for (int c = 1; c <= expq.size(); c++) begin
            @(negedge clk);
            start = 1'b0;
            TLTY  = (c < 5 + 5 * k);
            chk({tag, "_trace"}, 32'(obs), 32'(expq[c-1]));
            if (done && done_cyc == 0) done_cyc = c;
            if (ldr) ldr_seen++;
        end
        chk({tag, "_done_cycle"}, done_cyc, (n < MAXT) ? 5 * n + 6 : 5 * MAXT + 2);
        chk({tag, "_ldr_count"}, ldr_seen, n);
        chk({tag, "_terms"}, 32'(terms), n);
        @(negedge clk);
        chk({tag, "_idle_after"}, 32'({obs, terms}), 32'({12'd0, 4'(n)}));
    endtask

    initial begin
        int dcount;
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({obs, terms}), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_outputs", 32'({obs, terms}), 32'd0);

        run_check(0, "tlty0");
        run_check(2, "two_terms");
        run_check(20, "max_terms");

        // Abort during MULC of the second iteration (cycle 9).
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start = 1'b0;
            TLTY  = 1'b1;
            abort = (c == 9);
        end
        chk("abort_in_mulc", 32'(rsel), 32'd1);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", 32'({obs, terms}), 32'({12'd0, 4'd1}));
        dcount = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        chk("abort_no_done", dcount, 0);

        // Reset asserted during the first ACC (cycle 6).
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            TLTY  = 1'b1;
        end
        chk("rst_in_acc", 32'(ldr), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_midrun", 32'({obs, terms}), 32'd0);
        rst  = 1'b1;
        TLTY = 1'b0;
        run_check(1, "after_rst");

        // start held high with TLTY=0: done every 7 cycles, IDLE never skipped.
        @(negedge clk);
        start = 1'b1;
        TLTY  = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            chk("b2b_done", 32'(done), 32'(c % 7 == 6));
            if (c % 7 == 0) chk("b2b_idle", 32'(busy), 32'd0);
            if (c % 7 == 1) chk("b2b_load", 32'(ldx), 32'd1);
        end
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("b2b_quiet", 32'(busy), 32'd0);

        // Randomized run lengths, including ones past the limit.
        for (int r = 0; r < 8; r++) begin
            run_check(int'($urandom_range(0, 11)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cos_ctrl.md
# cos_ctrl

Moore-style sequencer for the 16-bit Q8.8 Taylor-series cosine datapath. It accepts a start request, drives the datapath's load/select/accumulate strobes through repeated multiply-by-x, multiply-by-x, multiply-by-coefficient and accumulate passes, and stops when the current term drops below the threshold `y` or after `MAX_TERMS` accumulations. It sits between the system-level request interface and the datapath. The result stays readable on the datapath `z` output after `done`.

## Interface
- `MAX_TERMS`, default 8: maximum number of accumulate passes, legal range 1..8.
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `abort`  in  1  in any non-IDLE state, return to IDLE on the next edge without pulsing `done`.
- `TLTY`  in  1  datapath status: 1 when the current term ≥ `y`, 0 when the term < `y`.
- `repcnt0`  in  1  datapath term-counter LSB.
- `ldx, ld0cnt, ld1, xsel, rsel, ldt, ldr, en, addsub, inccnt`  out  1 each  datapath strobes.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in DONE.
- `terms`  out  4  number of accumulates performed in the last or current run (0..8).

## Operation
- States: IDLE, LOAD, MULX1, MULX2, MULC, CHECK, ACC, DONE.
- IDLE: all strobes 0. If `start`=1, go to LOAD.
- LOAD: `ldx`=1, `ld0cnt`=1, `ld1`=1. The datapath captures x and sets the term and result registers to 0x0100 (1.0). `terms` is cleared. Go to MULX1.
- MULX1 and MULX2: `xsel`=1, `ldt`=1 (term ← term·x). MULX1 goes to MULX2; MULX2 goes to MULC.
- MULC: `rsel`=1, `ldt`=1 (term ← term·coef[cnt]). Go to CHECK.
- CHECK: no strobes (the term register is now stable for the compare).
  - `TLTY`=0: go to DONE; this term is discarded.
  - Otherwise: go to ACC.
- ACC: `en`=1, `ldr`=1, `inccnt`=1, `addsub`=`repcnt0`.
  - Even count subtracts; odd count adds. This gives the series 1 − x²/2 + x⁴/24 − …
  - `terms` increments.
  - If `terms` (post-increment) = `MAX_TERMS`, go to DONE; else go to MULX1.
- DONE: `done`=1. Go to IDLE. `start` is ignored here.
- Priority in every non-IDLE state: `rst` first, then `abort`, then the normal transition.
- Strobes never overlap except as listed. `xsel` and `rsel` are never both 1.

## Timing
- Reset: the state is IDLE and every output is 0, including `terms`=0, `busy`=0 and `done`=0.
- Reset asserted mid-run forces IDLE on that edge. The datapath registers are left as they are; the next LOAD reinitialises them.
- All outputs are decoded from the state register only (no combinational path from input to output).
- Latency:
  - Let `start` be sampled at edge 0.
  - A run with N accumulates that exits through CHECK asserts `done` in cycle 1 + 5N + 4 + 1 = 5N + 6.
  - A run that exits through the `MAX_TERMS` limit asserts `done` in cycle 5·`MAX_TERMS` + 2.
- Back-to-back runs: `start` held high gives IDLE for one cycle after DONE, then LOAD.
- `abort` sampled together with a CHECK or ACC exit condition: abort wins and `done` is not pulsed.
- `terms` holds its value after DONE until the next LOAD.

## Structure
- Shared package `cos_pkg`:
  - state enum `cos_state_t`;
  - constant `COS_ONE` = 16'h0100;
  - constant `COS_MAX_TERMS_LIMIT` = 8;
  - strobe-bundle struct for the datapath control word.
- No sub-module inside the controller: one state register, one 4-bit terms counter, and output decode.
- The integration wrapper `cos_unit` instantiates `cos_ctrl` and the datapath side by side.

## Test plan
- Reset, then `start` with `TLTY` held 0:
  - `done` in cycle 6; `terms`=0;
  - the strobe sequence is LOAD, MULX1, MULX2, MULC, then none;
  - `ldr` is never asserted.
- `start` with `TLTY`=1 for two CHECKs, then 0:
  - `terms`=2 and `done` in cycle 16;
  - `addsub` is 0 in the first ACC and 1 in the second (the bench toggles `repcnt0` after each `inccnt`).
- `TLTY` held 1, `MAX_TERMS`=8: 8 ACC pulses, `done` in cycle 42, `terms`=8.
- `abort` asserted during MULC of the second iteration: IDLE on the next edge, `done` never pulses, `busy` drops, `terms`=1.
- `rst` driven low during ACC: all outputs are 0 next cycle. A `start` after reset release runs a full sequence starting with LOAD.
- `start` held high continuously with `TLTY`=0:
  - `done` pulses every 7 cycles;
  - a `start` seen in DONE does not skip the IDLE cycle.
